// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Multi-cycle MIPS multiply/divide unit holding the architectural HI/LO
// registers. MULT/MULTU/DIV/DIVU are launched with a start strobe. The
// datapath is iterative: one shared 33-bit adder/subtractor plus the HI/LO
// accumulator shift registers. Every operation completes 34 edges after the
// start edge. MTHI/MTLO write HI/LO directly while the unit is idle.
//
// Handshake: start is accepted only at an edge where busy=0. A start seen
// while busy=1 is ignored and not queued, so the pipeline must hold the
// instruction until busy drops. done is a one-cycle pulse. It coincides with
// busy falling and with the new HI/LO values becoming visible.
//
// Optional feature (macro EARLY_OUT_EN): a divide by zero, or a multiply
// with a zero operand, skips the iteration phase. Its result appears 2 edges
// after start, and the result values match the full-latency path.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   start      operation request strobe
//   op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b       rs / rt operands (sampled at the start edge only)
//   hi_we      MTHI write enable (idle, no start)
//   lo_we      MTLO write enable (idle, no start)
//   wdata      MTHI/MTLO data
//   busy       operation in flight
//   done       one-cycle completion pulse
//   hi, lo     architectural HI/LO registers
//   state_dbg  current FSM state (0 IDLE, 1 CALC, 2 FIX)
// -----------------------------------------------------------------------------
module mult_div_unit #(
   parameter int XLEN = 32,
   parameter int ITER = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            hi_we,
   input  logic            lo_we,
   input  logic [XLEN-1:0] wdata,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo,
   output logic [1:0]      state_dbg
);

   localparam int CW = $clog2(ITER);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0]   cnt;        // iteration index inside CALC
   logic            fix_phase;  // 0: sign-correct, 1: commit to HI/LO
   logic            mul_r;      // operation in flight is a multiply
   logic            neg_hi;     // negate high half / remainder in FIX
   logic            neg_lo;     // negate low half / quotient in FIX
   logic [XLEN-1:0] opnd;       // multiplicand or divisor magnitude
   logic [XLEN-1:0] acc_hi;     // product high / partial remainder
   logic [XLEN-1:0] acc_lo;     // product low + multiplier / dividend -> quotient

   // ---------------------------------------------------------------------------
   // Operand conditioning at the start edge
   // ---------------------------------------------------------------------------
   logic            op_signed;
   logic            op_mul;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] mag_a;
   logic [XLEN-1:0] mag_b;
   logic            early;

   always_comb begin
      op_signed = ~op[0];
      op_mul    = ~op[1];
      a_neg     = op_signed & a[XLEN-1];
      b_neg     = op_signed & b[XLEN-1];
      // The magnitude of the most negative value is its own bit pattern,
      // which is the correct unsigned magnitude.
      mag_a     = a_neg ? (~a + XLEN'(1)) : a;
      mag_b     = b_neg ? (~b + XLEN'(1)) : b;
`ifdef EARLY_OUT_EN
      early     = op_mul ? ((a == '0) || (b == '0)) : (b == '0);
`else
      early     = 1'b0;
`endif
   end

   // ---------------------------------------------------------------------------
   // Shared adder: adds for multiply, subtracts for divide.
   // For subtraction the top bit of add_res is the no-borrow flag (x >= y).
   // ---------------------------------------------------------------------------
   logic [XLEN:0]   add_x;
   logic [XLEN:0]   add_y;
   logic            add_sub;
   logic [XLEN+1:0] add_res;
   logic [XLEN:0]   div_shift;
   logic            div_ge;
   logic [XLEN:0]   mul_sum;
   logic [XLEN-1:0] step_hi;
   logic [XLEN-1:0] step_lo;

   always_comb begin
      div_shift = {acc_hi, acc_lo[XLEN-1]};
      add_y     = {1'b0, opnd};
      if (mul_r) begin
         add_x   = {1'b0, acc_hi};
         add_sub = 1'b0;
      end else begin
         add_x   = div_shift;
         add_sub = 1'b1;
      end
      add_res = {1'b0, add_x} + {1'b0, add_y ^ {(XLEN+1){add_sub}}}
              + {{(XLEN+1){1'b0}}, add_sub};
      div_ge  = add_res[XLEN+1];

      if (mul_r) begin
         // Radix-2 shift-add: add the multiplicand when the multiplier LSB is
         // set, then shift the 65-bit {carry, hi, lo} right by one.
         mul_sum = acc_lo[0] ? add_res[XLEN:0] : {1'b0, acc_hi};
         step_hi = mul_sum[XLEN:1];
         step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
      end else begin
         // Restoring division: keep the difference only when it did not borrow.
         mul_sum = '0;
         step_hi = div_ge ? add_res[XLEN-1:0] : div_shift[XLEN-1:0];
         step_lo = {acc_lo[XLEN-2:0], div_ge};
      end
   end

   logic [2*XLEN-1:0] prod_neg;
   assign prod_neg = ~{acc_hi, acc_lo} + (2*XLEN)'(1);

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = early ? S_FIX : S_CALC;
         S_CALC: if (cnt == CW'(ITER-1)) state_nxt = S_FIX;
         S_FIX:  if (fix_phase) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      busy      = (state != S_IDLE);
      state_dbg = state;
   end

   // ---------------------------------------------------------------------------
   // Datapath and architectural registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         fix_phase <= 1'b0;
         mul_r     <= 1'b0;
         neg_hi    <= 1'b0;
         neg_lo    <= 1'b0;
         opnd      <= '0;
         acc_hi    <= '0;
         acc_lo    <= '0;
         hi        <= '0;
         lo        <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  // An accepted start takes precedence over MTHI/MTLO.
                  cnt       <= '0;
                  fix_phase <= 1'b0;
                  mul_r     <= op_mul;
                  acc_hi    <= '0;
                  if (op_mul) begin
                     opnd   <= mag_a;
                     acc_lo <= mag_b;
                     neg_hi <= a_neg ^ b_neg;
                     neg_lo <= a_neg ^ b_neg;
                  end else begin
                     opnd   <= mag_b;
                     acc_lo <= mag_a;
                     // Remainder follows the dividend sign. A divide by zero
                     // keeps the all-ones quotient unnegated.
                     neg_hi <= a_neg;
                     neg_lo <= (a_neg ^ b_neg) & (b != '0);
                  end
                  if (early) begin
                     // Same values the iterative path would have produced.
                     if (op_mul) begin
                        acc_hi <= '0;
                        acc_lo <= '0;
                     end else begin
                        acc_hi <= mag_a;
                        acc_lo <= '1;
                     end
                  end
               end else begin
                  if (hi_we) hi <= wdata;
                  if (lo_we) lo <= wdata;
               end
            end

            S_CALC: begin
               cnt    <= cnt + CW'(1);
               acc_hi <= step_hi;
               acc_lo <= step_lo;
            end

            S_FIX: begin
               if (!fix_phase) begin
                  fix_phase <= 1'b1;
                  if (mul_r) begin
                     if (neg_hi) {acc_hi, acc_lo} <= prod_neg;
                  end else begin
                     if (neg_hi) acc_hi <= ~acc_hi + XLEN'(1);
                     if (neg_lo) acc_lo <= ~acc_lo + XLEN'(1);
                  end
               end else begin
                  fix_phase <= 1'b0;
                  hi        <= acc_hi;
                  lo        <= acc_lo;
                  done      <= 1'b1;
               end
            end

            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//
// Table-driven bench for mult_div_unit. The directed vectors carry
// hand-computed HI/LO values. Hand-written sequences cover start/MT
// interference while busy, reset in mid-operation, and MT writes in idle or
// coincident with start.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [1:0]  state_dbg;

   int total;
   int bad;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   mult_div_unit dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .hi_we     (hi_we),
      .lo_we     (lo_we),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo),
      .state_dbg (state_dbg)
   );

   // ---------------------------------------------------------------------------
   // Clock
   // ---------------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish, want finish");
      $fatal(1, "timeout");
   end

   // ---------------------------------------------------------------------------
   // Checker
   // ---------------------------------------------------------------------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Expected latency from the start edge to done.
   function automatic int exp_latency(input logic [1:0] o, input logic [31:0] xa,
                                      input logic [31:0] xb);
      int lat;
      lat = 34;
`ifdef EARLY_OUT_EN
      if (o[1] ? (xb == 32'd0) : (xa == 32'd0 || xb == 32'd0)) lat = 2;
`endif
      return lat;
   endfunction

   // Wait for done, with a bounded cycle count. Returns the number of edges.
   task automatic wait_done(input int first_n, output int n);
      bit got;
      got = 1'b0;
      n   = first_n;
      while (!got && n < 100) begin
         @(posedge clk); #1;
         n++;
         if (done) got = 1'b1;
      end
   endtask

   // ---------------------------------------------------------------------------
   // Driver: one complete operation with result checks
   // ---------------------------------------------------------------------------
   task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] xa,
                         input logic [31:0] xb, input logic [31:0] eh,
                         input logic [31:0] el);
      int n;
      @(negedge clk);
      start = 1'b1; op = o; a = xa; b = xb;
      @(posedge clk); #1;
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      chk({nm, " busy_after_start"}, {31'd0, busy}, 32'd1);
      wait_done(0, n);
      chk({nm, " latency"}, n, exp_latency(o, xa, xb));
      chk({nm, " busy_at_done"}, {31'd0, busy}, 32'd0);
      chk({nm, " hi"}, hi, eh);
      chk({nm, " lo"}, lo, el);
      @(posedge clk); #1;
      chk({nm, " done_clears"}, {31'd0, done}, 32'd0);
   endtask

   // ---------------------------------------------------------------------------
   // Vector table
   // ---------------------------------------------------------------------------
   typedef struct {
      string       nm;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs[14];

   initial begin
      int n;
      logic [31:0] hi_before;

      vecs[0]  = '{"multu_max",    OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[1]  = '{"mult_m3x7",    OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[2]  = '{"div_m7d2",     OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{"divu_by0",     OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
      vecs[4]  = '{"div_ovf",      OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5]  = '{"divu_17d5",    OP_DIVU,  32'd17,       32'd5,        32'd2,        32'd3};
      vecs[6]  = '{"mult_minsq",   OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[7]  = '{"div_7dm2",     OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[8]  = '{"div_m7dm2",    OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
      vecs[9]  = '{"mult_xm1",     OP_MULT,  32'd12345,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFCFC7};
      vecs[10] = '{"div_neg_by0",  OP_DIV,   32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF};
      vecs[11] = '{"multu_zero",   OP_MULTU, 32'd0,        32'd5,        32'd0,        32'd0};
      vecs[12] = '{"divu_max_d1",  OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};
      vecs[13] = '{"multu_2p32",   OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

      total = 0;
      bad   = 0;

      // ---------------- reset ----------------
      reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
      repeat (2) @(negedge clk);
      chk("reset busy",  {31'd0, busy}, 32'd0);
      chk("reset done",  {31'd0, done}, 32'd0);
      chk("reset hi",    hi, 32'd0);
      chk("reset lo",    lo, 32'd0);
      chk("reset state", {30'd0, state_dbg}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // ---------------- table ----------------
      for (int i = 0; i < 14; i++)
         run_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);

      // ---------------- start and MTHI while busy are ignored ----------------
      @(negedge clk);
      start = 1'b1; op = OP_DIVU; a = 32'd17; b = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      hi_before = hi;
      repeat (9) @(posedge clk);
      @(negedge clk);
      start = 1'b1; op = OP_MULTU; a = 32'd9; b = 32'd9;
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
      @(posedge clk); #1;
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      chk("busy_mt hi_held", hi, hi_before);
      wait_done(10, n);
      chk("busy_mt latency", n, 32'd34);
      chk("busy_mt hi", hi, 32'd2);
      chk("busy_mt lo", lo, 32'd3);
      @(posedge clk); #1;
      chk("busy_mt no_queue", {31'd0, busy}, 32'd0);

      // ---------------- reset in mid-operation ----------------
      @(negedge clk);
      hi_we = 1'b1; lo_we = 1'b0; wdata = 32'h00001234;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h00005678;
      @(negedge clk);
      lo_we = 1'b0;
      chk("mt hi", hi, 32'h00001234);
      chk("mt lo", lo, 32'h00005678);
      start = 1'b1; op = OP_MULT; a = 32'd1000; b = 32'd1000;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midreset busy", {31'd0, busy}, 32'd0);
      chk("midreset done", {31'd0, done}, 32'd0);
      chk("midreset hi",   hi, 32'd0);
      chk("midreset lo",   lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_op("after_reset", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

      // ---------------- MT writes in idle and coincident with start ----------------
      @(negedge clk);
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFEF00D;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
      chk("mt_both hi", hi, 32'hCAFEF00D);
      chk("mt_both lo", lo, 32'hCAFEF00D);
      start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd4;
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h11111111;
      @(posedge clk); #1;
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      chk("mt_start hi_dropped", hi, 32'hCAFEF00D);
      chk("mt_start lo_dropped", lo, 32'hCAFEF00D);
      wait_done(0, n);
      chk("mt_start latency", n, 32'd34);
      chk("mt_start hi", hi, 32'd0);
      chk("mt_start lo", lo, 32'd12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
